// File: rtl/pa_hpcp_evt_cnt_bank_pkg.sv
// Shared definitions for the HPCP event counter bank: selector constants,
// selector legalisation and flattened-bus slicing helper.
`ifndef PA_HPCP_EVT_CNT_BANK_PKG_SV
`define PA_HPCP_EVT_CNT_BANK_PKG_SV

`define HPCP_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package pa_hpcp_evt_cnt_bank_pkg;

    localparam int unsigned SEL_NONE = 0;

    // Selector values naming a non-existent event line collapse to "no event".
    function automatic int unsigned hpcp_sel_legal(input int unsigned sel,
                                                   input int unsigned num_evt);
        return (sel >= num_evt) ? SEL_NONE : sel;
    endfunction

endpackage

`endif

// File: rtl/pa_hpcp_cnt_ch.sv
// Single HPCP counter channel: event selector, counter, increment logic and
// an optional sticky overflow flag (built only with PA_HPCP_OVF_INT_EN).
module pa_hpcp_cnt_ch
    import pa_hpcp_evt_cnt_bank_pkg::*;
#(
    parameter int unsigned EVT_W   = 5,
    parameter int unsigned NUM_EVT = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               cnt_clk,
    input  logic               cpurst_b,
    input  logic [CNT_W-1:0]   wdata,
    input  logic               sel_wen,
    input  logic               cnt_wen,
    input  logic [NUM_EVT-1:0] hpcp_event,
    input  logic               inh,
    input  logic               frz,
    output logic [EVT_W-1:0]   sel,
    output logic [CNT_W-1:0]   cnt,
    output logic               ovf
);

    logic [2**EVT_W-1:0] evt_ext;
    logic                inc;
    logic [EVT_W-1:0]    sel_new;

    // Zero-pad so every selector code indexes a defined bit.
    always_comb begin
        evt_ext                = '0;
        evt_ext[NUM_EVT-1:0]   = hpcp_event;
    end

    assign inc     = evt_ext[sel] & (sel != EVT_W'(SEL_NONE)) & ~inh & ~frz;
    assign sel_new = EVT_W'(hpcp_sel_legal(32'(wdata[EVT_W-1:0]), NUM_EVT));

    always_ff @(posedge cnt_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sel <= '0;
        end else if (sel_wen) begin
            sel <= sel_new;
        end
    end

    always_ff @(posedge cnt_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt <= '0;
        end else if (cnt_wen) begin
            cnt <= wdata;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PA_HPCP_OVF_INT_EN
    always_ff @(posedge cnt_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ovf <= 1'b0;
        end else if (cnt_wen) begin
            ovf <= 1'b0;
        end else if (inc && (cnt == '1)) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/pa_hpcp_evt_cnt_bank.sv
// Bank of NUM_CH HPCP counter channels sharing one event vector, plus the
// inhibit mask and overflow interrupt (PA_HPCP_OVF_INT_EN enables overflow).
module pa_hpcp_evt_cnt_bank
    import pa_hpcp_evt_cnt_bank_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned EVT_W   = 5,
    parameter int unsigned NUM_EVT = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                    cnt_clk,
    input  logic                    cpurst_b,
    input  logic [31:0]             hpcp_wdata,
    input  logic [NUM_CH-1:0]       hpcp_sel_wen,
    input  logic [NUM_CH-1:0]       hpcp_cnt_wen,
    input  logic                    hpcp_inh_wen,
    input  logic [NUM_EVT-1:0]      hpcp_event,
    input  logic                    cp0_hpcp_frz,
    output logic [NUM_CH*EVT_W-1:0] hpcp_sel_out,
    output logic [NUM_CH*CNT_W-1:0] hpcp_cnt_out,
    output logic [NUM_CH-1:0]       hpcp_inh_out,
    output logic [NUM_CH-1:0]       hpcp_ovf_out,
    output logic                    hpcp_ovf_int
);

    always_ff @(posedge cnt_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            hpcp_inh_out <= '0;
        end else if (hpcp_inh_wen) begin
            hpcp_inh_out <= hpcp_wdata[NUM_CH-1:0];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pa_hpcp_cnt_ch #(
            .EVT_W   (EVT_W),
            .NUM_EVT (NUM_EVT),
            .CNT_W   (CNT_W)
        ) u_ch (
            .cnt_clk    (cnt_clk),
            .cpurst_b   (cpurst_b),
            .wdata      (hpcp_wdata[CNT_W-1:0]),
            .sel_wen    (hpcp_sel_wen[i]),
            .cnt_wen    (hpcp_cnt_wen[i]),
            .hpcp_event (hpcp_event),
            .inh        (hpcp_inh_out[i]),
            .frz        (cp0_hpcp_frz),
            .sel        (`HPCP_SLICE(hpcp_sel_out, i, EVT_W)),
            .cnt        (`HPCP_SLICE(hpcp_cnt_out, i, CNT_W)),
            .ovf        (hpcp_ovf_out[i])
        );
    end

`ifdef PA_HPCP_OVF_INT_EN
    assign hpcp_ovf_int = |hpcp_ovf_out;
`else
    assign hpcp_ovf_int = 1'b0;
`endif

endmodule
